mem_stage_dport: RTL

//  MEM-stage data-port controller of the pipelined RV32I core. Consumes the EX/MEM control word
//  (opcode, funct3, data_read/data_write intent), the ALU effective address and rs2 data.

---
 rtl/mem_stage_dport_pkg.sv | 78 +++++++
 rtl/mem_stage_dport_load_align.sv | 35 +++
 rtl/mem_stage_dport.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_dport_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_dport_pkg
// Shared types and helpers for the MEM-stage data port of the RV32I core:
// opcode constants, load/store funct3 encodings, the data-port FSM state type
// and the pure functions that build byte enables, store data and the
// alignment/legality checks.
// -----------------------------------------------------------------------------
package mem_stage_dport_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dport_state_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    // Store byte enables; word stores (and anything else) enable all lanes.
    function automatic logic [3:0] gen_mbe(input logic [2:0] funct3, input logic [1:0] offset);
        logic [3:0] mbe_s;
        case (funct3)
            SB:      mbe_s = 4'b0001 << offset;
            SH:      mbe_s = 4'b0011 << offset;
            default: mbe_s = 4'b1111;
        endcase
        return mbe_s;
    endfunction

    // Replicate the store operand into every lane so the byte enables alone
    // select where it lands.
    function automatic logic [31:0] gen_wdata(input logic [2:0] funct3, input logic [31:0] rs2);
        logic [31:0] wdata_s;
        case (funct3)
            SB:      wdata_s = {4{rs2[7:0]}};
            SH:      wdata_s = {2{rs2[15:0]}};
            default: wdata_s = rs2;
        endcase
        return wdata_s;
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic mis_s;
        case (funct3[1:0])
            2'b01:   mis_s = offset[0];
            2'b10:   mis_s = (offset != 2'b00);
            default: mis_s = 1'b0;
        endcase
        return mis_s;
    endfunction

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        logic ok_s;
        if (is_store) begin
            ok_s = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
        end else begin
            ok_s = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                   (funct3 == LBU) || (funct3 == LHU);
        end
        return ok_s;
    endfunction

endpackage

// File: rtl/mem_stage_dport_load_align.sv
// -----------------------------------------------------------------------------
// mem_stage_dport_load_align
// Purely combinational load formatter: shifts the addressed byte/half/word of
// the read word down to bit 0 and sign- or zero-extends it per funct3.
// Ports:
//   rdata     in  32  raw word returned by the data cache
//   offset    in  2   byte offset of the access within the word
//   funct3    in  3   load funct3 (lb/lh/lw/lbu/lhu)
//   load_data out 32  aligned, extended result
// -----------------------------------------------------------------------------
module mem_stage_dport_load_align
    import mem_stage_dport_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [31:0] shifted_s;

    // Lane selection followed by width-dependent extension.
    always_comb begin
        shifted_s = rdata >> {offset, 3'b000};
        case (funct3)
            LB:      load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            LH:      load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            LBU:     load_data = {24'h000000, shifted_s[7:0]};
            LHU:     load_data = {16'h0000, shifted_s[15:0]};
            LW:      load_data = rdata;
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_dport.sv
// -----------------------------------------------------------------------------
// mem_stage_dport
// MEM-stage data-port controller. Accepts a load/store from the EX/MEM
// register, drives the data-cache request/response handshake, stalls the
// pipeline until the access retires and returns the formatted load result.
// FSM: IDLE (accept or fault) -> BUSY (request held until resp/timeout)
//      -> DONE (release stall, load_valid for loads) -> IDLE.
// Parameters:
//   MAX_WAIT  BUSY cycles before the access is abandoned; 0 = wait forever
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mem_valid, opcode, funct3   EX/MEM control word
//   addr, rs2_data              effective address, store operand
//   stall                       freeze IF..MEM registers
//   data_read, data_write       dcache request strobes
//   data_mem_address            word-aligned address
//   data_mbe, data_mem_wdata    byte enables, lane-replicated store data
//   data_mem_rdata, data_mem_resp  dcache read data and completion pulse
//   load_data, load_valid       formatted load result and its strobe
//   access_fault                misaligned / illegal funct3 / timeout pulse
// -----------------------------------------------------------------------------
module mem_stage_dport
    import mem_stage_dport_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 0
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] rs2_data,
    output logic        stall,
    output logic        data_read,
    output logic        data_write,
    output logic [31:0] data_mem_address,
    output logic [3:0]  data_mbe,
    output logic [31:0] data_mem_wdata,
    input  logic [31:0] data_mem_rdata,
    input  logic        data_mem_resp,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_fault
);

    dport_state_t state_r;
    dport_state_t state_next_s;

    logic [31:0] addr_r;
    logic [2:0]  funct3_r;
    logic        is_load_r;
    logic        is_store_r;
    logic [31:0] wdata_r;
    logic [3:0]  mbe_r;
    logic [31:0] rdata_r;

    logic access_s;
    logic store_s;
    logic bad_s;
    logic accept_s;
    logic timeout_s;

    assign store_s  = (opcode == OP_STORE);
    assign access_s = mem_valid && ((opcode == OP_LOAD) || store_s);
    assign bad_s    = access_s && (!funct3_legal(store_s, funct3) ||
                                   is_misaligned(funct3, addr[1:0]));
    assign accept_s = access_s && !bad_s;

    // Next-state and handshake/stall decode.
    always_comb begin
        state_next_s = state_r;
        stall        = 1'b0;
        data_read    = 1'b0;
        data_write   = 1'b0;
        load_valid   = 1'b0;
        access_fault = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    stall        = 1'b1;
                    state_next_s = BUSY;
                end else if (bad_s) begin
                    access_fault = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                data_read  = is_load_r;
                data_write = is_store_r;
                if (data_mem_resp) begin
                    stall        = 1'b1;
                    state_next_s = DONE;
                end else if (timeout_s) begin
                    // Abandon the access; releasing stall lets the faulting
                    // instruction leave MEM just like an IDLE-detected fault.
                    access_fault = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            DONE: begin
                load_valid   = is_load_r;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register plus capture of the accepted access and its read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            addr_r     <= 32'h0000_0000;
            funct3_r   <= 3'b000;
            is_load_r  <= 1'b0;
            is_store_r <= 1'b0;
            wdata_r    <= 32'h0000_0000;
            mbe_r      <= 4'b0000;
            rdata_r    <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            if ((state_r == IDLE) && accept_s) begin
                addr_r     <= addr;
                funct3_r   <= funct3;
                is_load_r  <= !store_s;
                is_store_r <= store_s;
                wdata_r    <= gen_wdata(funct3, rs2_data);
                mbe_r      <= store_s ? gen_mbe(funct3, addr[1:0]) : 4'b1111;
            end
            if ((state_r == BUSY) && data_mem_resp) begin
                rdata_r <= data_mem_rdata;
            end
        end
    end

    generate
        if (MAX_WAIT != 0) begin : g_wait
            localparam int unsigned CW = $clog2(MAX_WAIT + 1);
            localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
            localparam logic [CW-1:0] WAIT_MAX  = CW'(MAX_WAIT);
            logic [CW-1:0] wait_cnt_r;

            // BUSY-cycle counter: cleared on accept, saturating.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wait_cnt_r <= '0;
                end else if ((state_r == IDLE) && accept_s) begin
                    wait_cnt_r <= '0;
                end else if ((state_r == BUSY) && (wait_cnt_r != WAIT_MAX)) begin
                    wait_cnt_r <= wait_cnt_r + CW'(1);
                end else begin
                    wait_cnt_r <= wait_cnt_r;
                end
            end

            assign timeout_s = (state_r == BUSY) && (wait_cnt_r == WAIT_LAST);
        end else begin : g_nowait
            assign timeout_s = 1'b0;
        end
    endgenerate

    assign data_mem_address = {addr_r[31:2], 2'b00};
    assign data_mbe         = mbe_r;
    assign data_mem_wdata   = wdata_r;

    mem_stage_dport_load_align u_load_align (
        .rdata     (rdata_r),
        .offset    (addr_r[1:0]),
        .funct3    (funct3_r),
        .load_data (load_data)
    );

endmodule
